bus_fabric_ws: RTL
==================

Name: bus_fabric_ws

Overview:
Parametrised successor to the fixed top-level chip-select decode and read mux. It sits between the CPU data port and N_SLAVES memory-mapped slaves (IO, RAM, future peripherals). It decodes the upper address bits to a one-hot chip select and runs a request/ack handshake, so slaves may insert wait states. It returns registered read data with an error flag for unmapped or hung accesses.

Parameters:
ADDR_W, 16, master address width
DATA_W, 16, data width
SEL_W, 2, number of upper address bits used as the region select
N_SLAVES, 4, number of populated regions; must satisfy N_SLAVES <= 2**SEL_W; regions with sel >= N_SLAVES are unmapped
TIMEOUT_CYCLES, 64, ACCESS-state cycles before forced error (used only with BUS_TIMEOUT_EN)
ERR_DATA, 16'h0000, m_rdata value returned on an error response

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
m_req  in  1  master request; held with m_addr/m_wdata/m_write stable until m_ready
m_addr  in  ADDR_W  master byte/word address
m_wdata  in  DATA_W  master write data
m_write  in  1  1 = write, 0 = read
m_rdata  out  DATA_W  registered read data, valid while m_ready=1
m_ready  out  1  one-cycle completion pulse
m_err  out  1  error qualifier, valid while m_ready=1
s_cs  out  N_SLAVES  one-hot slave select
s_addr  out  ADDR_W-SEL_W  region offset, registered
s_wdata  out  DATA_W  registered write data
s_we  out  1  registered write strobe, qualified by s_cs
s_rdata  in  N_SLAVES*DATA_W  packed slave read data; slice i belongs to slave i
s_ack  in  N_SLAVES  per-slave completion; may be asserted in the first cs cycle

Behaviour:
- Single clock (clk). Asynchronous active-high reset (rst).
- Reset state: IDLE. s_cs=0, s_we=0, s_addr=0, s_wdata=0, m_ready=0, m_err=0, m_rdata=0.
- sel = m_addr[ADDR_W-1 -: SEL_W]. offset = m_addr[ADDR_W-SEL_W-1:0].
- State IDLE: when m_req=1 and sel < N_SLAVES, register s_cs=1<<sel, s_addr, s_wdata and s_we=m_write, then go to ACCESS. When m_req=1 and sel >= N_SLAVES, go to RESP with m_err=1 and m_rdata=ERR_DATA; no s_cs is asserted.
- State ACCESS: s_cs is held and the latched sel is used.
  - On s_ack[sel]=1: m_rdata <= s_rdata slice sel (reads; writes load the same value, which is don't-care for the master), m_err=0. s_cs, s_we <= 0. Go to RESP.
  - s_ack bits of unselected slaves are ignored.
- State RESP: m_ready=1 for exactly one cycle, then IDLE. m_rdata holds its value until the next response.
- Minimum latency: m_req sampled at cycle 0, s_cs high at cycle 1, ack at cycle 1, m_ready at cycle 2. Each wait state adds one cycle.
- Back-to-back: IDLE re-samples m_req on the cycle after RESP. A master holding m_req high issues the next access there. Peak rate is one access per 3 cycles.
- m_req dropping during ACCESS is a protocol violation; the transaction still completes and m_ready still pulses.
- m_addr/m_wdata changes after IDLE sampling have no effect (latched).
- rst asserted mid-transaction: immediate return to IDLE with all outputs at reset values; no m_ready for the aborted access.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a counter clears on ACCESS entry and increments each ACCESS cycle without ack.
- Reaching TIMEOUT_CYCLES-1 with no ack forces RESP with m_err=1, m_rdata=ERR_DATA, and drops s_cs/s_we. An ack in the same cycle wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for ack.

Decomposition:
- Package bus_pkg: state enum (IDLE, ACCESS, RESP), default DATA_W/ADDR_W constants, ERR_DATA default.
- Sub-module bus_timeout_cnt (clear, enable, expire) instantiated only under BUS_TIMEOUT_EN.
- Decode, select latch and response mux stay in bus_fabric_ws.

Test Plan:
- Read slave 1, ack in first cs cycle, s_rdata slice1=16'h1234, m_addr=16'h4005 -> s_cs=4'b0010, s_addr=14'h0005; m_ready at cycle 2 with m_rdata=16'h1234, m_err=0.
- Write slave 0, m_addr=16'h0010, m_wdata=16'hA5A5, ack after 3 wait cycles -> s_we=1, s_wdata=16'hA5A5 held for 4 cycles; m_ready at cycle 5; s_cs=0 at cycle 5.
- N_SLAVES=3, access m_addr=16'hC000 -> s_cs stays 0; m_ready at cycle 1 with m_err=1, m_rdata=16'h0000.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave 2 never acks -> m_ready and m_err=1 exactly 8 ACCESS cycles after s_cs rises; ack arriving in cycle 8 instead gives m_err=0.
- rst pulsed during ACCESS with slave 1 selected -> s_cs=0 and m_ready=0 asynchronously; the next request after release completes normally.
- m_req held high for two reads to slaves 0 then 1 -> m_ready pulses 3 cycles apart; each m_rdata matches its own slice.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus fabric.
// Holds the FSM state enum and the default bus widths.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;
    localparam logic [15:0] BUS_ERR_DATA = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_fabric_ws_if.sv
// CPU-side and slave-side signals of the bus fabric.
// master/slave modports for the endpoints, fabric for the decoder.
interface bus_fabric_ws_if
    import bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int SEL_W    = 2,
    parameter int N_SLAVES = 4
);

    logic                       m_req;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic                       m_write;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_ready;
    logic                       m_err;

    logic [N_SLAVES-1:0]        s_cs;
    logic [ADDR_W-SEL_W-1:0]    s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic                       s_we;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;
    logic [N_SLAVES-1:0]        s_ack;

    modport master (
        output m_req, m_addr, m_wdata, m_write,
        input  m_rdata, m_ready, m_err
    );

    modport slave (
        input  s_cs, s_addr, s_wdata, s_we,
        output s_rdata, s_ack
    );

    modport fabric (
        input  m_req, m_addr, m_wdata, m_write,
        output m_rdata, m_ready, m_err,
        output s_cs, s_addr, s_wdata, s_we,
        input  s_rdata, s_ack
    );

endinterface

// File: rtl/bus_timeout_cnt.sv
// ACCESS-state watchdog, used only when BUS_TIMEOUT_EN is defined.
// expire is high once TIMEOUT_CYCLES-1 ack-less cycles have elapsed.
module bus_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear dominates; otherwise count ack-less wait cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_fabric_ws.sv
// Chip-select decoder with wait-state handshake and registered read mux.
// Optional watchdog on ACCESS enabled by defining BUS_TIMEOUT_EN.
module bus_fabric_ws
    import bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int SEL_W          = 2,
    parameter int N_SLAVES       = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(BUS_ERR_DATA)
) (
    input logic            clk,
    input logic            rst,
    bus_fabric_ws_if.fabric bus
);

    localparam int OFF_W = ADDR_W - SEL_W;
    localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N_SLAVES);

    bus_state_e state_q, state_d;

    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_SLAVES-1:0] cs_q, cs_d;
    logic                we_q, we_d;
    logic [OFF_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [SEL_W-1:0]  sel;
    logic [OFF_W-1:0]  offset;
    logic              mapped;
    logic              ack_sel;
    logic [DATA_W-1:0] rd_sel;
    logic              expire;

    assign sel    = bus.m_addr[ADDR_W-1 -: SEL_W];
    assign offset = bus.m_addr[OFF_W-1:0];
    assign mapped = ({1'b0, sel} < N_SEL);

    // Pick ack and read data of the latched slave only.
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ack_sel = bus.s_ack[i];
                rd_sel  = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != ACCESS),
        .enable(state_q == ACCESS && !ack_sel),
        .expire(expire)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: unmapped goes straight to RESP; ack beats timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m_req) begin
                    state_d = mapped ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (ack_sel || expire) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and response capture.
    always_comb begin
        sel_d   = sel_q;
        cs_d    = cs_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m_req && mapped) begin
                    sel_d   = sel;
                    cs_d    = N_SLAVES'(1) << sel;
                    we_d    = bus.m_write;
                    addr_d  = offset;
                    wdata_d = bus.m_wdata;
                end else if (bus.m_req) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                end
            end
            ACCESS: begin
                if (ack_sel) begin
                    rdata_d = rd_sel;
                    err_d   = 1'b0;
                    cs_d    = '0;
                    we_d    = 1'b0;
                end else if (expire) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    cs_d    = '0;
                    we_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            cs_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Drive bus outputs; m_ready is the RESP state itself.
    always_comb begin
        bus.m_ready = (state_q == RESP);
        bus.m_err   = err_q;
        bus.m_rdata = rdata_q;
        bus.s_cs    = cs_q;
        bus.s_we    = we_q;
        bus.s_addr  = addr_q;
        bus.s_wdata = wdata_q;
    end

endmodule
